// File: rtl/gpx2_spi_burst_master.sv
// SPI burst master for TDC-GPX2 register/result access.
// Streams multi-word frames under one chip select, with a runtime SPI mode,
// an upstream write-word fetch, and per-word read strobes.
module gpx2_spi_burst_master #(
  parameter int DATA_W             = 8,
  parameter int LEN_W              = 4,
  parameter int CLK_DIV_NUM        = 4,
  parameter int SPICOM_INRV_CLKCNT = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  output logic              o_spi_ssn,
  output logic              o_spi_dclk,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso,
  input  logic [1:0]        i_spi_mode,
  input  logic              i_spicom_req,
  input  logic [LEN_W-1:0]  i_spicom_len,
  input  logic [DATA_W-1:0] i_spi_wdata,
  output logic              o_spi_wrreq,
  output logic              o_spicom_ready,
  output logic              o_spi_rdvalid,
  output logic [DATA_W-1:0] o_spi_rdbyte,
  output logic              o_spicom_done,
  output logic              o_spicom_err
);

  localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int CNT_MAX = (CLK_DIV_NUM > SPICOM_INRV_CLKCNT) ? CLK_DIV_NUM : SPICOM_INRV_CLKCNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV_NUM - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SPICOM_INRV_CLKCNT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, GAP} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               phase, phase_n;
  logic [BIT_W-1:0]   bit_cnt, bit_n;
  logic [LEN_W-1:0]   word_cnt, word_n;
  logic               accept, reject, lead_ev, trail_ev;

  logic [1:0]         mode_q;
  logic [LEN_W-1:0]   len_q;
  logic [DATA_W-1:0]  wbuf, tx_sh, rx_sh;
  logic               wr_pend, rx_done;

  logic               ssn_n, dclk_n, ready_n, done_n, err_n;
  logic               launch_ev, sample_ev, new_word, more_words, no_launch;
  logic [LEN_W:0]     word_w, len_w;

  // State register; reset lands in GAP so the inter-frame gap also follows reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= GAP;
      cnt      <= '0;
      phase    <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      phase    <= phase_n;
      bit_cnt  <= bit_n;
      word_cnt <= word_n;
    end
  end

  // Next-state logic: each SCLK half-period starts with an edge except the final idle half
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    phase_n  = phase;
    bit_n    = bit_cnt;
    word_n   = word_cnt;
    accept   = 1'b0;
    reject   = 1'b0;
    lead_ev  = 1'b0;
    trail_ev = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (i_spicom_req) begin
          if (i_spicom_len == '0) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = CS_SETUP;
          end
        end
      end
      CS_SETUP: begin
        if (cnt == DIV_LAST) begin
          state_n = SHIFT;
          cnt_n   = '0;
          phase_n = 1'b0;
          bit_n   = '0;
          word_n  = '0;
          lead_ev = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == DIV_LAST) begin
          cnt_n = '0;
          if (!phase) begin
            phase_n  = 1'b1;
            trail_ev = 1'b1;
          end else if (bit_cnt == BIT_LAST && word_cnt == len_q - LEN_W'(1)) begin
            state_n = CS_HOLD;
          end else begin
            phase_n = 1'b0;
            lead_ev = 1'b1;
            if (bit_cnt == BIT_LAST) begin
              bit_n  = '0;
              word_n = word_cnt + LEN_W'(1);
            end else begin
              bit_n = bit_cnt + BIT_W'(1);
            end
          end
        end
      end
      CS_HOLD: begin
        if (cnt == DIV_LAST) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = GAP;
        cnt_n   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered control pins derived from the transition
  always_comb begin
    ssn_n   = !(state_n == CS_SETUP || state_n == SHIFT || state_n == CS_HOLD);
    ready_n = (state_n == IDLE);
    done_n  = (state == CS_HOLD) && (state_n == GAP);
    err_n   = reject;
    dclk_n  = o_spi_dclk;
    if (state_n == IDLE || state_n == GAP || accept) begin
      dclk_n = i_spi_mode[1];
    end else if (lead_ev) begin
      dclk_n = ~mode_q[1];
    end else if (trail_ev) begin
      dclk_n = mode_q[1];
    end
  end

  // Control pin registers so no input reaches an output combinationally
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_spi_ssn      <= 1'b1;
      o_spi_dclk     <= 1'b0;
      o_spicom_ready <= 1'b0;
      o_spicom_done  <= 1'b0;
      o_spicom_err   <= 1'b0;
    end else begin
      o_spi_ssn      <= ssn_n;
      o_spi_dclk     <= dclk_n;
      o_spicom_ready <= ready_n;
      o_spicom_done  <= done_n;
      o_spicom_err   <= err_n;
    end
  end

  assign word_w = {1'b0, word_n};
  assign len_w  = {1'b0, len_q};

  // CPHA picks which SCLK edge launches and which samples; word 0 in CPHA=0 is launched at accept
  always_comb begin
    launch_ev = mode_q[0] ? lead_ev : trail_ev;
    sample_ev = mode_q[0] ? trail_ev : lead_ev;
    if (mode_q[0]) begin
      new_word   = (bit_n == '0);
      more_words = (word_w + (LEN_W+1)'(1)) < len_w;
      no_launch  = 1'b0;
    end else begin
      new_word   = (bit_n == BIT_LAST);
      more_words = (word_w + (LEN_W+1)'(2)) < len_w;
      no_launch  = new_word && (word_n == len_q - LEN_W'(1));
    end
  end

  // Shift datapath: write-word fetch, MOSI launch, MISO capture and read strobe
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q        <= '0;
      len_q         <= '0;
      wbuf          <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      wr_pend       <= 1'b0;
      rx_done       <= 1'b0;
      o_spi_mosi    <= 1'b0;
      o_spi_wrreq   <= 1'b0;
      o_spi_rdvalid <= 1'b0;
      o_spi_rdbyte  <= '0;
    end else begin
      o_spi_wrreq   <= 1'b0;
      o_spi_rdvalid <= 1'b0;
      rx_done       <= 1'b0;
      wr_pend       <= o_spi_wrreq;
      if (wr_pend) begin
        wbuf <= i_spi_wdata;
      end
      if (accept) begin
        mode_q <= i_spi_mode;
        len_q  <= i_spicom_len;
        if (i_spi_mode[0]) begin
          wbuf <= i_spi_wdata;
        end else begin
          o_spi_mosi  <= i_spi_wdata[DATA_W-1];
          tx_sh       <= i_spi_wdata << 1;
          o_spi_wrreq <= (i_spicom_len > LEN_W'(1));
        end
      end
      if (launch_ev && !no_launch) begin
        if (new_word) begin
          o_spi_mosi  <= wbuf[DATA_W-1];
          tx_sh       <= wbuf << 1;
          o_spi_wrreq <= more_words;
        end else begin
          o_spi_mosi <= tx_sh[DATA_W-1];
          tx_sh      <= tx_sh << 1;
        end
      end
      if (sample_ev) begin
        rx_sh   <= {rx_sh[DATA_W-2:0], i_spi_miso};
        rx_done <= (bit_n == BIT_LAST);
      end
      if (rx_done) begin
        o_spi_rdbyte  <= rx_sh;
        o_spi_rdvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gpx2_spi_burst_master.sv
// Directed self-checking bench for gpx2_spi_burst_master with a behavioural SPI slave.
module tb_gpx2_spi_burst_master;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       o_spi_ssn, o_spi_dclk, o_spi_mosi, i_spi_miso;
  logic [1:0] i_spi_mode;
  logic       i_spicom_req;
  logic [3:0] i_spicom_len;
  logic [7:0] i_spi_wdata;
  logic       o_spi_wrreq, o_spicom_ready, o_spi_rdvalid, o_spicom_done, o_spicom_err;
  logic [7:0] o_spi_rdbyte;

  int checks = 0;
  int failures = 0;

  // Monitor counters, written only by the monitor and slave processes
  int ssn_low_cnt = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0, err_cnt = 0, sclk_cnt = 0;
  logic [7:0] rd_log [8];

  // Slave model and stimulus state
  logic [7:0] slave_pat = 8'h00;
  logic [7:0] slave_rx = 8'h00;
  logic [1:0] slave_mode = 2'b00;
  logic       loopback = 1'b0;
  logic       miso_bit = 1'b0;
  logic       in_frame = 1'b0;
  logic       prev_dclk = 1'b0;
  logic       lead;
  int         idx = 0;
  logic [7:0] word_tab [4];
  int         wr_base = 0;

  int done0, ssn0, rd0, wr0, sclk0, err0, lat;

  gpx2_spi_burst_master dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .o_spi_ssn      (o_spi_ssn),
    .o_spi_dclk     (o_spi_dclk),
    .o_spi_mosi     (o_spi_mosi),
    .i_spi_miso     (i_spi_miso),
    .i_spi_mode     (i_spi_mode),
    .i_spicom_req   (i_spicom_req),
    .i_spicom_len   (i_spicom_len),
    .i_spi_wdata    (i_spi_wdata),
    .o_spi_wrreq    (o_spi_wrreq),
    .o_spicom_ready (o_spicom_ready),
    .o_spi_rdvalid  (o_spi_rdvalid),
    .o_spi_rdbyte   (o_spi_rdbyte),
    .o_spicom_done  (o_spicom_done),
    .o_spicom_err   (o_spicom_err)
  );

  always #5 i_clk = ~i_clk;

  assign i_spi_miso  = loopback ? o_spi_mosi : miso_bit;
  assign i_spi_wdata = word_tab[2'(wr_cnt - wr_base)];

  // Count pulses and low cycles on the falling clock edge, away from DUT updates
  always @(negedge i_clk) begin
    if (!o_spi_ssn) ssn_low_cnt++;
    if (o_spicom_done) done_cnt++;
    if (o_spicom_err) err_cnt++;
    if (o_spi_wrreq) wr_cnt++;
    if (o_spi_rdvalid) begin
      rd_log[rd_cnt % 8] = o_spi_rdbyte;
      rd_cnt++;
    end
  end

  // SPI slave: launches pattern bits on its launch edge and captures MOSI on its sample edge
  always @(o_spi_ssn or o_spi_dclk) begin
    if (o_spi_ssn) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      in_frame  = 1'b1;
      idx       = 0;
      slave_rx  = 8'h00;
      prev_dclk = o_spi_dclk;
      if (!slave_mode[0]) miso_bit = slave_pat[7];
    end else if (o_spi_dclk != prev_dclk) begin
      prev_dclk = o_spi_dclk;
      lead = (o_spi_dclk != slave_mode[1]);
      if (lead) sclk_cnt++;
      if (lead == !slave_mode[0]) begin
        slave_rx = {slave_rx[6:0], o_spi_mosi};
      end else if (!slave_mode[0]) begin
        idx++;
        miso_bit = slave_pat[7 - (idx % 8)];
      end else begin
        miso_bit = slave_pat[7 - (idx % 8)];
        idx++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic waitReady();
    bit seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge i_clk);
      if (o_spicom_ready) seen = 1'b1;
    end
    if (!seen) checkOutput("ready_timeout", 0, 1);
  endtask

  // Posedges until ready rises, sampled 1ns after each edge
  task automatic countToReady(output int n);
    bit seen = 1'b0;
    n = 0;
    while (n < 50 && !seen) begin
      @(posedge i_clk);
      #1;
      n++;
      if (o_spicom_ready) seen = 1'b1;
    end
    if (!seen) n = -1;
  endtask

  task automatic waitDone(output int latency);
    bit seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(negedge i_clk);
      if (o_spicom_done) seen = 1'b1;
    end
    if (!seen) begin
      checkOutput("done_timeout", 0, 1);
      latency = -1;
    end else begin
      countToReady(latency);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] len, input logic [7:0] w0,
                               input logic [7:0] w1, input logic [7:0] w2, input logic loop,
                               input logic [7:0] pat);
    word_tab[0] = w0;
    word_tab[1] = w1;
    word_tab[2] = w2;
    word_tab[3] = 8'h00;
    wr_base     = wr_cnt;
    loopback    = loop;
    slave_pat   = pat;
    slave_mode  = mode;
    i_spi_mode  = mode;
    repeat (2) @(negedge i_clk);
    waitReady();
    done0 = done_cnt; ssn0 = ssn_low_cnt; rd0 = rd_cnt; wr0 = wr_cnt; sclk0 = sclk_cnt; err0 = err_cnt;
    i_spicom_len = len;
    i_spicom_req = 1'b1;
    @(posedge i_clk);
    #1;
    i_spicom_req = 1'b0;
  endtask

  initial begin
    i_rst        = 1'b1;
    i_spi_mode   = 2'b01;
    i_spicom_req = 1'b0;
    i_spicom_len = 4'd0;
    word_tab[0] = 8'h00; word_tab[1] = 8'h00; word_tab[2] = 8'h00; word_tab[3] = 8'h00;
    #23;
    checkOutput("rst_ssn", o_spi_ssn, 1);
    checkOutput("rst_dclk", o_spi_dclk, 0);
    checkOutput("rst_mosi", o_spi_mosi, 0);
    checkOutput("rst_ready", o_spicom_ready, 0);
    checkOutput("rst_wrreq", o_spi_wrreq, 0);
    checkOutput("rst_rdvalid", o_spi_rdvalid, 0);
    checkOutput("rst_rdbyte", o_spi_rdbyte, 0);
    checkOutput("rst_done", o_spicom_done, 0);
    checkOutput("rst_err", o_spicom_err, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    countToReady(lat);
    checkOutput("rst_ready_lat", lat, 5);

    // Single word, mode 1, loopback
    applyStimulus(2'b01, 4'd1, 8'h25, 8'h00, 8'h00, 1'b1, 8'h00);
    checkOutput("single_ssn_t1", o_spi_ssn, 0);
    checkOutput("single_ready_t1", o_spicom_ready, 0);
    waitDone(lat);
    checkOutput("single_ready_lat", lat, 5);
    checkOutput("single_ssn_low", ssn_low_cnt - ssn0, 72);
    checkOutput("single_done", done_cnt - done0, 1);
    checkOutput("single_rdvalid", rd_cnt - rd0, 1);
    checkOutput("single_rdbyte", rd_log[rd0 % 8], 8'h25);
    checkOutput("single_mosi_bits", slave_rx, 8'h25);
    checkOutput("single_sclk", sclk_cnt - sclk0, 8);
    checkOutput("single_wrreq", wr_cnt - wr0, 0);

    // Three-word bursts in mode 0 and mode 1, loopback
    for (int m = 0; m < 2; m++) begin
      applyStimulus(2'(m), 4'd3, 8'hA5, 8'h3C, 8'h0F, 1'b1, 8'h00);
      waitDone(lat);
      checkOutput("burst_wrreq", wr_cnt - wr0, 2);
      checkOutput("burst_sclk", sclk_cnt - sclk0, 24);
      checkOutput("burst_rdvalid", rd_cnt - rd0, 3);
      checkOutput("burst_rd0", rd_log[rd0 % 8], 8'hA5);
      checkOutput("burst_rd1", rd_log[(rd0 + 1) % 8], 8'h3C);
      checkOutput("burst_rd2", rd_log[(rd0 + 2) % 8], 8'h0F);
      checkOutput("burst_ssn_low", ssn_low_cnt - ssn0, 200);
      checkOutput("burst_done", done_cnt - done0, 1);
    end

    // Mode 0 against a fixed slave pattern
    i_spi_mode = 2'b00;
    repeat (2) @(negedge i_clk);
    checkOutput("mode0_dclk_idle", o_spi_dclk, 0);
    applyStimulus(2'b00, 4'd1, 8'hC3, 8'h00, 8'h00, 1'b0, 8'h5A);
    checkOutput("mode0_msb_early", o_spi_mosi, 1);
    waitDone(lat);
    checkOutput("mode0_mosi_bits", slave_rx, 8'hC3);
    checkOutput("mode0_rdbyte", rd_log[rd0 % 8], 8'h5A);

    // Mode 3 against the same pattern
    i_spi_mode = 2'b11;
    repeat (2) @(negedge i_clk);
    checkOutput("mode3_dclk_idle", o_spi_dclk, 1);
    applyStimulus(2'b11, 4'd1, 8'hC3, 8'h00, 8'h00, 1'b0, 8'h5A);
    checkOutput("mode3_dclk_setup", o_spi_dclk, 1);
    waitDone(lat);
    checkOutput("mode3_mosi_bits", slave_rx, 8'hC3);
    checkOutput("mode3_rdbyte", rd_log[rd0 % 8], 8'h5A);
    checkOutput("mode3_sclk", sclk_cnt - sclk0, 8);

    // Zero-length request is rejected
    i_spi_mode = 2'b01;
    slave_mode = 2'b01;
    waitReady();
    ssn0 = ssn_low_cnt; err0 = err_cnt;
    i_spicom_len = 4'd0;
    i_spicom_req = 1'b1;
    @(posedge i_clk);
    #1;
    i_spicom_req = 1'b0;
    checkOutput("reject_err", o_spicom_err, 1);
    checkOutput("reject_ssn", o_spi_ssn, 1);
    checkOutput("reject_ready", o_spicom_ready, 1);
    @(posedge i_clk);
    #1;
    checkOutput("reject_err_pulse", o_spicom_err, 0);
    repeat (20) @(negedge i_clk);
    checkOutput("reject_no_frame", ssn_low_cnt - ssn0, 0);
    checkOutput("reject_err_cnt", err_cnt - err0, 1);

    // A request while busy is neither taken nor queued
    applyStimulus(2'b01, 4'd1, 8'h25, 8'h00, 8'h00, 1'b1, 8'h00);
    repeat (10) @(negedge i_clk);
    i_spicom_req = 1'b1;
    repeat (5) @(negedge i_clk);
    i_spicom_req = 1'b0;
    waitDone(lat);
    repeat (30) @(negedge i_clk);
    checkOutput("busy_done", done_cnt - done0, 1);
    checkOutput("busy_ssn_low", ssn_low_cnt - ssn0, 72);

    // Reset in the middle of a frame
    applyStimulus(2'b01, 4'd1, 8'h25, 8'h00, 8'h00, 1'b1, 8'h00);
    for (int n = 0; n < 500 && (sclk_cnt - sclk0) < 4; n++) @(negedge i_clk);
    checkOutput("midrst_reached", sclk_cnt - sclk0, 4);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("midrst_ssn", o_spi_ssn, 1);
    checkOutput("midrst_dclk", o_spi_dclk, 0);
    checkOutput("midrst_ready", o_spicom_ready, 0);
    @(negedge i_clk);
    i_rst = 1'b0;
    countToReady(lat);
    checkOutput("midrst_ready_lat", lat, 5);
    checkOutput("midrst_no_done", done_cnt - done0, 0);
    checkOutput("midrst_no_rdvalid", rd_cnt - rd0, 0);
    applyStimulus(2'b01, 4'd1, 8'h25, 8'h00, 8'h00, 1'b1, 8'h00);
    waitDone(lat);
    checkOutput("after_rst_rdbyte", rd_log[rd0 % 8], 8'h25);
    checkOutput("after_rst_mosi_bits", slave_rx, 8'h25);
    checkOutput("after_rst_done", done_cnt - done0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpx2_spi_burst_master.md
# gpx2_spi_burst_master

Parametrised SPI master for TDC-GPX2 register and result access. It succeeds the single-byte master with these additions:
- multi-word frames under one chip-select
- configurable word width
- runtime-selectable SPI mode (CPOL/CPHA)
- explicit chip-select output, streaming write-data fetch, frame-done and error flags

It sits between the configuration/readout controller and the GPX2 SPI pins, in the `i_clk` domain.

## Interface
Parameters:
- `DATA_W`, 8: bits per SPI word, MSB first.
- `LEN_W`, 4: width of the word-count field; maximum frame length is 2^LEN_W−1 words.
- `CLK_DIV_NUM`, 4: `i_clk` cycles per SCLK half-period; minimum 2.
- `SPICOM_INRV_CLKCNT`, 5: `i_clk` cycles of enforced SSN-high gap between frames; minimum 1.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `o_spi_ssn`  out  1  chip select, active low.
- `o_spi_dclk`  out  1  SPI clock.
- `o_spi_mosi`  out  1  serial data out.
- `i_spi_miso`  in  1  serial data in.
- `i_spi_mode`  in  2  {CPOL, CPHA}; latched when a request is accepted.
- `i_spicom_req`  in  1  frame request.
- `i_spicom_len`  in  LEN_W  number of words in the frame.
- `i_spi_wdata`  in  DATA_W  write word.
- `o_spi_wrreq`  out  1  one-cycle pulse requesting the next write word.
- `o_spicom_ready`  out  1  idle; a request can be accepted.
- `o_spi_rdvalid`  out  1  one-cycle pulse: `o_spi_rdbyte` holds a new word.
- `o_spi_rdbyte`  out  DATA_W  last received word.
- `o_spicom_done`  out  1  one-cycle pulse when SSN deasserts at frame end.
- `o_spicom_err`  out  1  one-cycle pulse: request rejected because `len` = 0.

## Operation
- **States:**
  - IDLE → CS_SETUP → SHIFT → CS_HOLD → GAP → IDLE.
  - Reset enters GAP, so ready first rises SPICOM_INRV_CLKCNT cycles after reset release.
- **Accept condition:**
  - A request is accepted when `i_spicom_req` & `o_spicom_ready` are both high at a rising `i_clk` edge.
  - On accept, capture `i_spi_mode`, `i_spicom_len` and `i_spi_wdata` (word 0).
  - A request made while ready=0 is ignored and is not queued.
- **len = 0:** no frame is started, SSN stays high, `o_spicom_err` pulses the next cycle, and the block stays in IDLE.
- **SCLK idle level:**
  - In IDLE/GAP, `o_spi_dclk` = registered `i_spi_mode[1]`.
  - From accept to the end of CS_HOLD, `o_spi_dclk` idles at the latched CPOL.
- **CPHA=0:** MSB is driven on MOSI at CS_SETUP entry. MISO is sampled on the leading SCLK edge; the next bit is shifted out on the trailing edge.
- **CPHA=1:** a bit is shifted out on the leading edge; MISO is sampled on the trailing edge.
- **Word boundaries:** words are back-to-back with no gap and no extra SCLK edges. The total is exactly DATA_W×len SCLK pulses.
- **Write streaming:**
  - For every word k < len−1, `o_spi_wrreq` pulses for one cycle when bit MSB of word k is launched.
  - The block captures `i_spi_wdata` as word k+1 exactly one cycle after that pulse.
  - Upstream must present the word by then; this is not checked.
- **Read:** `o_spi_rdbyte` updates and `o_spi_rdvalid` pulses one cycle after the last sample edge of each word. The value holds until the next word completes.
- **Frame end:**
  - CS_HOLD lasts CLK_DIV_NUM cycles.
  - SSN rises, and `o_spicom_done` pulses, in the same cycle that GAP is entered.
  - GAP lasts SPICOM_INRV_CLKCNT cycles, then IDLE.
- **Mid-frame inputs:** changes to `i_spi_mode`/`i_spicom_len` during a frame have no effect.
- **Reset mid-frame:** all outputs go to their reset values immediately (asynchronous). The partial frame is abandoned; no done, rdvalid or err pulse is produced.

## Timing
- **Reset values:**
  - `o_spi_ssn`=1
  - `o_spi_dclk`=0
  - `o_spi_mosi`=0
  - `o_spicom_ready`=0
  - `o_spi_wrreq`=0
  - `o_spi_rdvalid`=0
  - `o_spi_rdbyte`=0
  - `o_spicom_done`=0
  - `o_spicom_err`=0
- **Cycle T (accept):**
  - At T+1, SSN=0 and ready=0.
  - CS_SETUP lasts CLK_DIV_NUM cycles before the first SCLK edge.
- **SSN-low duration:** CLK_DIV_NUM×(2 + 2×DATA_W×len) cycles.
- **Turnaround:** ready rises SPICOM_INRV_CLKCNT cycles after SSN rises, i.e. in the cycle after GAP ends.
- **Output registration:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Single word:** reset, mode=01, len=1, wdata=0x25, MISO looped to MOSI.
  - MOSI shifts 0,0,1,0,0,1,0,1 on leading edges.
  - rdbyte=0x25 with one rdvalid pulse.
  - SSN low for 72 cycles; done pulses once; ready returns 5 cycles after SSN rises.
- **Burst:** len=3, words 0xA5, 0x3C, 0x0F supplied on wrreq, with loopback.
  - Exactly 2 wrreq pulses and 24 SCLK pulses.
  - rdvalid pulses 3 times with 0xA5, 0x3C, 0x0F.
  - SSN low for 200 cycles.
- **Modes 0 and 3:** mode 0, wdata=0xC3, MISO fixed to pattern 0x5A.
  - SCLK idles 0 (mode 0) / 1 (mode 3).
  - Sampling is on the correct edge and rdbyte=0x5A.
  - MSB is valid before the first edge in mode 0.
- **Reject/ignore:**
  - len=0 → err pulse, SSN stays 1, ready stays 1.
  - A second req asserted while busy → no second frame.
- **Reset mid-frame:** assert i_rst after 3 bits have shifted.
  - SSN=1, dclk=0 and ready=0 take effect asynchronously.
  - After release, ready=1 after 5 cycles; no done pulse is seen.
  - The next frame (0x25) completes correctly.
